// File: rtl/lpc_pkg.sv
// Shared LPC definitions: FSM states, protocol nibbles, bus widths and window decode.
package lpc_pkg;

    localparam int unsigned LAD_W      = 4;
    localparam int unsigned IO_ADDR_W  = 16;
    localparam int unsigned REG_ADDR_W = 8;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned CNT_W      = 2;

    localparam logic [LAD_W-1:0] LPC_START  = 4'h0;
    localparam logic [LAD_W-1:0] CYC_IO_RD  = 4'h0;
    localparam logic [LAD_W-1:0] CYC_IO_WR  = 4'h2;
    localparam logic [LAD_W-1:0] SYNC_READY = 4'h0;
    localparam logic [LAD_W-1:0] TAR_DRIVE  = 4'hF;

    typedef enum logic [3:0] {
        IDLE,
        START,
        CYCTYPE,
        ADDR,
        WDATA,
        HTAR,
        SYNC,
        RDATA,
        TTAR
    } lpc_state_t;

    // True when the upper address bits match the window base.
    function automatic logic win_hit(input logic [IO_ADDR_W-1:0] a,
                                     input logic [IO_ADDR_W-1:0] base,
                                     input int unsigned          log2);
        return (a >> log2) == (base >> log2);
    endfunction

endpackage

// File: rtl/lpc_io_slave.sv
// LPC I/O-cycle target: decodes host I/O read/write cycles hitting the register
// window and drives SYNC/TAR/data back; strobes the downstream register file.
module lpc_io_slave
    import lpc_pkg::*;
#(
    parameter logic [IO_ADDR_W-1:0] BASE_ADDR = 16'h0A00,
    parameter int unsigned          WIN_LOG2  = 5
) (
    input  logic                  LpcClock,
    input  logic                  PciReset,
    input  logic                  LFrame_n,
    input  logic [LAD_W-1:0]      LadIn,
    output logic [LAD_W-1:0]      LadOut,
    output logic                  LadOe,
    output logic [REG_ADDR_W-1:0] Addr,
    output logic                  Wr,
    output logic [DATA_W-1:0]     DataWr,
    output logic                  Rd,
    input  logic [DATA_W-1:0]     RdData
);

    localparam int unsigned           SHIFT_W  = IO_ADDR_W - LAD_W;
    localparam logic [IO_ADDR_W-1:0]  WIN_MASK = IO_ADDR_W'((32'd1 << WIN_LOG2) - 32'd1);

    lpc_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   is_wr_q, is_wr_d;
    logic [SHIFT_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [REG_ADDR_W-1:0]  addr_out_q, addr_out_d;
    logic                   lad_oe_q, lad_oe_d;
    logic [LAD_W-1:0]       lad_out_q, lad_out_d;
    logic                   wr_q, wr_d;
    logic                   rd_q, rd_d;
    logic [IO_ADDR_W-1:0]   io_addr;

    // Full 16-bit address as it stands after this clock's nibble is shifted in.
    assign io_addr = {addr_q, LadIn};

    // State and shadow registers; reset abandons any cycle in flight.
    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rdata_q    <= '0;
            addr_out_q <= '0;
            lad_oe_q   <= 1'b0;
            lad_out_q  <= TAR_DRIVE;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rdata_q    <= rdata_d;
            addr_out_q <= addr_out_d;
            lad_oe_q   <= lad_oe_d;
            lad_out_q  <= lad_out_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    // Next-state and next-output decode; an LFRAME# assertion overrides everything.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
        addr_out_d = addr_out_q;
        lad_oe_d   = lad_oe_q;
        lad_out_d  = lad_out_q;
        wr_d       = 1'b0;
        rd_d       = 1'b0;

        if (!LFrame_n) begin
            state_d   = (LadIn == LPC_START) ? START : IDLE;
            cnt_d     = '0;
            lad_oe_d  = 1'b0;
            lad_out_d = TAR_DRIVE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    lad_oe_d  = 1'b0;
                    lad_out_d = TAR_DRIVE;
                end
                // First clock after the frame: LAD carries the cycle type.
                START: begin
                    cnt_d = '0;
                    if (LadIn == CYC_IO_RD) begin
                        is_wr_d = 1'b0;
                        state_d = ADDR;
                    end else if (LadIn == CYC_IO_WR) begin
                        is_wr_d = 1'b1;
                        state_d = ADDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ADDR: begin
                    addr_d = io_addr[SHIFT_W-1:0];
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        cnt_d = '0;
                        if (win_hit(io_addr, BASE_ADDR, WIN_LOG2)) begin
                            addr_out_d = REG_ADDR_W'(io_addr & WIN_MASK);
                            if (is_wr_q) begin
                                state_d = WDATA;
                            end else begin
                                state_d = HTAR;
                                rd_d    = 1'b1;
                            end
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                WDATA: begin
                    if (cnt_q == 2'd0) begin
                        data_d[LAD_W-1:0] = LadIn;
                        cnt_d             = 2'd1;
                    end else begin
                        data_d[DATA_W-1:LAD_W] = LadIn;
                        cnt_d                  = '0;
                        state_d                = HTAR;
                    end
                end
                // Host turnaround; its last clock launches SYNC (and Wr for writes).
                HTAR: begin
                    if (cnt_q == 2'd0) begin
                        cnt_d = 2'd1;
                    end else begin
                        cnt_d     = '0;
                        state_d   = SYNC;
                        lad_oe_d  = 1'b1;
                        lad_out_d = SYNC_READY;
                        wr_d      = is_wr_q;
                        if (!is_wr_q) begin
                            rdata_d = RdData;
                        end
                    end
                end
                SYNC: begin
                    if (is_wr_q) begin
                        state_d   = TTAR;
                        lad_out_d = TAR_DRIVE;
                    end else begin
                        state_d   = RDATA;
                        cnt_d     = '0;
                        lad_out_d = rdata_q[LAD_W-1:0];
                    end
                end
                RDATA: begin
                    if (cnt_q == 2'd0) begin
                        cnt_d     = 2'd1;
                        lad_out_d = rdata_q[DATA_W-1:LAD_W];
                    end else begin
                        cnt_d     = '0;
                        state_d   = TTAR;
                        lad_out_d = TAR_DRIVE;
                    end
                end
                TTAR: begin
                    state_d   = IDLE;
                    lad_oe_d  = 1'b0;
                    lad_out_d = TAR_DRIVE;
                end
                default: begin
                    state_d   = IDLE;
                    lad_oe_d  = 1'b0;
                    lad_out_d = TAR_DRIVE;
                end
            endcase
        end
    end

    assign LadOut = lad_out_q;
    assign LadOe  = lad_oe_q;
    assign Addr   = addr_out_q;
    assign Wr     = wr_q;
    assign DataWr = data_q;
    assign Rd     = rd_q;

endmodule
